// File: rtl/video_status_reader.sv
// video_status_reader: sweeps five video-memory words per frame and commits lives/doors/positions atomically
module video_status_reader #(
  parameter int          RD_LATENCY    = 1,
  parameter logic [31:0] ADDR_P1_LIVES = 32'h6000,
  parameter logic [31:0] ADDR_P2_LIVES = 32'h7000,
  parameter logic [31:0] ADDR_DOORS    = 32'h8000,
  parameter logic [31:0] ADDR_P1_POS   = 32'h9000,
  parameter logic [31:0] ADDR_P2_POS   = 32'hA000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refresh_req,
  input  logic [31:0] video_data,
  output logic [31:0] vga_addr,
  output logic [1:0]  p1_lives,
  output logic [1:0]  p2_lives,
  output logic [1:0]  correct_door_1,
  output logic [1:0]  correct_door_2,
  output logic [1:0]  player_1_pos,
  output logic [1:0]  player_2_pos,
  output logic        busy,
  output logic        snapshot_valid,
  output logic        field_changed,
  output logic        door_error
);
  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;
  state_t state, state_nx;
  logic pending, start, cap, door_eq;
  logic [1:0] cnt;
  logic [2:0] idx;
  logic [1:0] sh_p1, sh_p2, sh_d1, sh_d2, sh_q1, sh_q2, nd1, nd2;
  logic [31:0] addr_nx;
  logic unused_bits;
  assign unused_bits = ^video_data[31:4];
  assign busy = state != IDLE;
  // next state, capture strobe, next read address and door-commit selection
  always_comb begin
    start    = state == IDLE && (refresh_req || pending);
    cap      = state == FETCH && cnt == 2'(RD_LATENCY);
    state_nx = start ? FETCH : (cap && idx == 3'd4) ? COMMIT : state == COMMIT ? IDLE : state;
    addr_nx  = idx == 3'd0 ? ADDR_P2_LIVES : idx == 3'd1 ? ADDR_DOORS : idx == 3'd2 ? ADDR_P1_POS : ADDR_P2_POS;
    door_eq  = sh_d1 == sh_d2;
    nd1      = door_eq ? correct_door_1 : sh_d1;
    nd2      = door_eq ? correct_door_2 : sh_d2;
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // sweep sequencing, shadow capture and atomic commit
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      cnt <= '0;
      idx <= '0;
      vga_addr <= ADDR_P1_LIVES;
      {sh_p1, sh_p2, sh_d1, sh_d2, sh_q1, sh_q2} <= 12'hF10;
      {p1_lives, p2_lives, correct_door_1, correct_door_2, player_1_pos, player_2_pos} <= 12'hF10;
      snapshot_valid <= 1'b0;
      field_changed <= 1'b0;
      door_error <= 1'b0;
    end else begin
      snapshot_valid <= 1'b0;
      field_changed <= 1'b0;
      if (busy && refresh_req) pending <= 1'b1;
      else if (start) pending <= 1'b0;
      if (start) begin
        vga_addr <= ADDR_P1_LIVES;
        cnt <= '0;
        idx <= '0;
      end
      if (state == FETCH) begin
        cnt <= cap ? 2'd0 : cnt + 2'd1;
        if (cap) begin
          idx <= idx + 3'd1;
          if (idx != 3'd4) vga_addr <= addr_nx;
          sh_p1 <= idx == 3'd0 ? video_data[1:0] : sh_p1;
          sh_p2 <= idx == 3'd1 ? video_data[1:0] : sh_p2;
          sh_d1 <= idx == 3'd2 ? video_data[1:0] : sh_d1;
          sh_d2 <= idx == 3'd2 ? video_data[3:2] : sh_d2;
          sh_q1 <= idx == 3'd3 ? video_data[1:0] : sh_q1;
          sh_q2 <= idx == 3'd4 ? video_data[1:0] : sh_q2;
        end
      end
      if (state == COMMIT) begin
        {p1_lives, p2_lives, correct_door_1, correct_door_2, player_1_pos, player_2_pos} <= {sh_p1, sh_p2, nd1, nd2, sh_q1, sh_q2};
        field_changed <= {sh_p1, sh_p2, nd1, nd2, sh_q1, sh_q2} != {p1_lives, p2_lives, correct_door_1, correct_door_2, player_1_pos, player_2_pos};
        snapshot_valid <= 1'b1;
        door_error <= door_eq;
      end
    end
  end
endmodule

// File: doc/video_status_reader.md
VIDEO_STATUS_READER -- requirements
Module: video_status_reader

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning cycles from vga_addr change to valid video_data (1..3).
REQ-002 SHALL have parameters ADDR_P1_LIVES 32'h6000, ADDR_P2_LIVES 32'h7000, ADDR_DOORS 32'h8000, ADDR_P1_POS 32'h9000, ADDR_P2_POS 32'h A000, meaning video-memory word addresses read in that order.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock (VGA pixel clock); all state changes on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 refresh_req  input  1  one-cycle request to start a read sweep (frame start).
REQ-007 video_data  input  32  read-port data from video memory.
REQ-008 vga_addr  output  32  registered read-port address to video memory.
REQ-009 p1_lives, p2_lives  output  2 each  committed lives, video_data[1:0].
REQ-010 correct_door_1, correct_door_2  output  2 each  committed doors, video_data[1:0] and [3:2] of ADDR_DOORS word.
REQ-011 player_1_pos, player_2_pos  output  2 each  committed positions, video_data[1:0].
REQ-012 busy  output  1  sweep in progress.
REQ-013 snapshot_valid  output  1  one-cycle pulse on commit.
REQ-014 field_changed  output  1  one-cycle pulse with snapshot_valid when any committed field differs from its prior value.
REQ-015 door_error  output  1  last sweep read correct_door_1 == correct_door_2.

Function
REQ-016 SHALL implement states IDLE, FETCH, COMMIT; IDLE->FETCH on refresh_req or pending flag; FETCH->COMMIT after 5th capture; COMMIT->IDLE unconditionally.
REQ-017 On accept edge N SHALL set vga_addr=ADDR_P1_LIVES and busy=1.
REQ-018 Each field SHALL occupy RD_LATENCY+1 cycles: video_data sampled at edge N+k*(RD_LATENCY+1), k=1..5, same edge loads next address.
REQ-019 Captures SHALL go to shadow registers only; outputs unchanged during FETCH.
REQ-020 At edge N+5*(RD_LATENCY+1)+1 (N+11 default) SHALL copy shadows to outputs, pulse snapshot_valid, drop busy.
REQ-021 If shadow doors equal, SHALL keep previous door outputs, set door_error=1; else update doors, door_error=0; lives/positions commit regardless.
REQ-022 field_changed SHALL compare new committed values (held doors if error) against old outputs.
REQ-023 refresh_req while busy or in COMMIT SHALL set one-deep pending flag; extra requests dropped; pending sweep accepted at edge after COMMIT (N+12 default).
REQ-024 refresh_req in IDLE with pending clear SHALL start immediately; never two sweeps concurrently.
REQ-025 video_data upper bits unused fields SHALL be ignored.
REQ-026 After COMMIT, vga_addr SHALL hold ADDR_P2_POS until next accept.

Reset
REQ-027 Reset SHALL force IDLE, pending=0, busy=0, snapshot_valid=0, field_changed=0, door_error=0, vga_addr=ADDR_P1_LIVES.
REQ-028 Reset SHALL set p1_lives=p2_lives=2'b11, correct_door_1=2'b00, correct_door_2=2'b01, player_1_pos=player_2_pos=2'b00, shadows to same.
REQ-029 Reset mid-sweep SHALL abort sweep, discard shadows, no snapshot_valid; reset dominates simultaneous refresh_req.

Verification
REQ-030 Memory model latency 1 with 6000->2, 7000->1, 8000->4'b0110, 9000->3, A000->0; pulse refresh_req at edge N -> addresses 6000,7000,8000,9000,A000 at N..N+8 step 2; at N+11 p1=2,p2=1,door1=2,door2=1,pos1=3,pos2=0, snapshot_valid and field_changed 1 for one cycle.
REQ-031 Repeat identical sweep -> snapshot_valid=1, field_changed=0.
REQ-032 8000->4'b1010 -> door_error=1, doors hold previous (2,1), lives/positions update; next sweep with 4'b0110 -> door_error=0.
REQ-033 refresh_req three times during busy -> exactly one extra sweep starting at N+12; total two snapshot_valid pulses.
REQ-034 Reset asserted at N+5 -> no snapshot_valid, outputs at reset values, busy=0 next cycle; new refresh_req works normally.
REQ-035 RD_LATENCY=3 -> commit at N+21, captured data correct despite stale data on video_data in intermediate cycles.
